// File: rtl/bb_pkg.sv
// Definitions shared by master_bb and slave_bb: FSM states, mode encoding, error data
// and the request record carried across the inter-group link.
package bb_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } bb_state_e;

    localparam logic       MODE_WRITE = 1'b1;
    localparam logic       MODE_READ  = 1'b0;
    localparam logic [7:0] ERR_DATA   = 8'hFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        mode;
    } bb_req_t;
endpackage

// File: rtl/master_bb_if.sv
// Local bus seen from the bridge: arbitration handshake, command strobe and slave response.
interface master_bb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) ();
    logic                  breq;
    logic                  bgrant;
    logic [ADDR_WIDTH-1:0] m_address;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic                  m_mode;
    logic                  m_valid;
    logic                  m_rvalid;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport master (
        output breq, m_address, m_wdata, m_mode, m_valid,
        input  bgrant, m_rvalid, m_rdata
    );

    modport slave (
        input  breq, m_address, m_wdata, m_mode, m_valid,
        output bgrant, m_rvalid, m_rdata
    );
endinterface

// File: rtl/bb_req_fifo.sv
// Two-entry first-word-fall-through request queue; the head is always visible on head.
module bb_req_fifo #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage carries no reset: an entry is only observed once count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign count = count_r;
endmodule

// File: rtl/master_bb.sv
// Master-side bus bridge: queues remote requests, wins the local bus, issues each one
// and returns the slave's response (or an error after a response timeout).
module master_bb
    import bb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bb_address,
    input  logic [DATA_WIDTH-1:0] bb_wdata,
    input  logic                  bb_mode,
    input  logic                  bb_valid,
    output logic [DATA_WIDTH-1:0] bb_rdata,
    output logic                  bb_rvalid,
    master_bb_if.master           bus,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout
);
    localparam int         REQ_W     = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    bb_state_e             state, state_next;
    logic [REQ_W-1:0]      fifo_din, fifo_head;
    logic [1:0]            fifo_count;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] head_addr, cmd_addr;
    logic [DATA_WIDTH-1:0] head_wdata, cmd_wdata, resp_data;
    logic                  head_mode, cmd_mode;
    logic                  err_flag, overflow_r, tmo_hit;
    logic [7:0]            tmo_cnt;

    assign push       = bb_valid && (fifo_count != 2'd2);
    assign fifo_din   = {bb_address, bb_wdata, bb_mode};
    assign head_addr  = fifo_head[REQ_W-1 -: ADDR_WIDTH];
    assign head_wdata = fifo_head[DATA_WIDTH:1];
    assign head_mode  = fifo_head[0];
    assign tmo_hit    = (tmo_cnt + 8'd1) == TMO_LIMIT;

    bb_req_fifo #(.WIDTH(REQ_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE:  if (fifo_count != 2'd0) state_next = ST_REQ;
            ST_REQ:   if (bus.bgrant) state_next = ST_ISSUE;
            ST_ISSUE: begin
                pop        = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT:  if (bus.m_rvalid || tmo_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // A slave response in the same cycle as the timeout hit takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_mode   <= 1'b0;
            resp_data  <= '0;
            err_flag   <= 1'b0;
            tmo_cnt    <= 8'd0;
            overflow_r <= 1'b0;
        end else begin
            if (bb_valid && (fifo_count == 2'd2)) overflow_r <= 1'b1;
            case (state)
                ST_ISSUE: begin
                    cmd_addr  <= head_addr;
                    cmd_wdata <= head_wdata;
                    cmd_mode  <= head_mode;
                    tmo_cnt   <= 8'd0;
                    err_flag  <= 1'b0;
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus.m_rvalid) begin
                        resp_data <= bus.m_rdata;
                        err_flag  <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_data <= DATA_WIDTH'(ERR_DATA);
                        err_flag  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.breq      = (state == ST_REQ) || (state == ST_ISSUE) || (state == ST_WAIT);
    assign bus.m_valid   = (state == ST_ISSUE);
    assign bus.m_address = (state == ST_ISSUE) ? head_addr  : cmd_addr;
    assign bus.m_wdata   = (state == ST_ISSUE) ? head_wdata : cmd_wdata;
    assign bus.m_mode    = (state == ST_ISSUE) ? head_mode  : cmd_mode;
    assign bb_rvalid     = (state == ST_RESP);
    assign bb_rdata      = resp_data;
    assign timeout       = (state == ST_RESP) && err_flag;
    assign busy          = (state != ST_IDLE) || (fifo_count != 2'd0);
    assign overflow      = overflow_r;
endmodule

// File: doc/master_bb.md
# master_bb

Master-side bus bridge: the initiating end of the inter-group link whose responding end is `slave_bb`. It accepts transaction requests (address, write data, mode) arriving from a remote group's `slave_bb`, queues up to two, and arbitrates for the local bus. It then issues each request as a local bus master and returns the slave's response (read data or write acknowledge) to the remote group.

## Interface

Parameters:
- `ADDR_WIDTH`, 16, address width.
- `DATA_WIDTH`, 8, data width.
- `TIMEOUT`, 64, maximum cycles in WAIT before an error response (1..255).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `bb_address`  in  ADDR_WIDTH  request address from the remote bridge.
- `bb_wdata`  in  DATA_WIDTH  request write data.
- `bb_mode`  in  1  1 = write, 0 = read.
- `bb_valid`  in  1  one-cycle request strobe.
- `bb_rdata`  out  DATA_WIDTH  response data to the remote bridge.
- `bb_rvalid`  out  1  one-cycle response strobe.
- `breq`  out  1  local bus request to the arbiter.
- `bgrant`  in  1  local bus grant.
- `m_address`  out  ADDR_WIDTH  local bus address.
- `m_wdata`  out  DATA_WIDTH  local bus write data.
- `m_mode`  out  1  local bus mode.
- `m_valid`  out  1  one-cycle local bus command strobe.
- `m_rvalid`  in  1  slave response strobe; used as the read-data or write acknowledge.
- `m_rdata`  in  DATA_WIDTH  slave read data.
- `busy`  out  1  high whenever state ≠ IDLE or the queue is non-empty.
- `overflow`  out  1  sticky: a request was dropped; cleared only by `rst`.
- `timeout`  out  1  one-cycle pulse coinciding with an error response.

## Operation

- **Request queue:** 2-entry FIFO of {address, wdata, mode}.
  - Push when `bb_valid` is high and count < 2.
  - If `bb_valid` is high with count = 2, drop the request and set `overflow`.
  - Push and pop in the same cycle are legal; count is unchanged.
- **FSM states:** IDLE, REQ, ISSUE, WAIT, RESP.
  - **IDLE:** go to REQ when the registered count ≠ 0.
  - **REQ:** `breq`=1. Go to ISSUE when `bgrant`=1.
  - **ISSUE:** `breq`=1, `m_valid`=1.
    - `m_address`/`m_wdata`/`m_mode` come from the FIFO head; pop the head this cycle.
    - Latch the head into the command registers; they hold their value until the next ISSUE.
    - Clear the timeout counter. Go to WAIT unconditionally.
  - **WAIT:** `breq`=1. Increment the timeout counter each cycle.
    - On `m_rvalid`=1: capture `m_rdata` and go to RESP.
    - If the counter reaches TIMEOUT first: load the response with 8'hFF, flag an error, go to RESP.
    - If `m_rvalid` and the timeout hit occur in the same cycle, `m_rvalid` wins.
  - **RESP:** `breq`=0, `bb_rvalid`=1, `bb_rdata` = captured value.
    - `timeout`=1 if the error flag is set.
    - Go to IDLE.
- Write responses also return the captured `m_rdata` (the value the slave drives is passed through, not interpreted).
- `m_rvalid` outside WAIT is ignored.
- `bgrant` deasserting during ISSUE or WAIT is ignored; the transaction completes.
- All outputs are decoded from registered state and registered datapath; there is no combinational input-to-output path.

## Timing

- **Reset:** all outputs 0, state IDLE, FIFO empty, `overflow` 0, counter 0.
  - `rst` mid-transaction aborts it immediately: no `bb_rvalid`, and queued entries are discarded.
- **Latency, with `bgrant` held high:**
  - `bb_valid` in cycle N → REQ (`breq`=1) in N+2.
  - ISSUE (`m_valid`=1) in N+3.
  - WAIT from N+4.
  - `m_rvalid` in cycle M → `bb_rvalid` in M+1.
- **Grant wait:** each cycle of `bgrant` delay adds one cycle in REQ.
- **Back-to-back:** RESP → IDLE → REQ, giving at least 2 cycles between consecutive `m_valid` pulses plus grant and response time.
- **Timeout:** the error response appears in the cycle after the TIMEOUT-th WAIT cycle.
- **Counter width:** 8 bits; no wrap, because the timeout hit leaves WAIT.

## Structure

- **Package `bb_pkg`:**
  - state enum.
  - `MODE_WRITE`=1, `MODE_READ`=0.
  - `ERR_DATA`=8'hFF.
  - request struct {addr, wdata, mode}.
  - Shared with `slave_bb`.
- **Sub-module `bb_req_fifo`:** 2-deep, first-word-fall-through, with count output; instantiated once.
- FSM, command registers, response register and timeout counter live in `master_bb`.

## Test plan

- **Reset:** assert `rst` 2 cycles with random inputs → every output 0, `busy`=0.
- **Write:** `bb_valid` with 16'h1234/8'hAB/mode 1, `bgrant` high → `breq` at N+2, `m_valid` at N+3 with 1234/AB/1. Slave `m_rvalid` 2 cycles later with 8'h00 → `bb_rvalid`=1, `bb_rdata`=00 the next cycle.
- **Read with delayed grant:** read request with 16'h5678, `bgrant` raised 5 cycles after `breq` → `m_valid` the cycle after grant. `m_rdata`=8'hCD → `bb_rdata`=CD; `breq` low in the RESP cycle.
- **Overflow:** three consecutive `bb_valid` (addrs 0x0001, 0x0002, 0x0003) with `bgrant` low → `overflow`=1. Then grant → exactly two `m_valid` pulses, addresses 0001 then 0002.
- **Timeout:** read request, slave never answers → after 64 WAIT cycles, `bb_rvalid`=1, `bb_rdata`=FF, `timeout`=1; FSM returns to IDLE.
- **Reset mid-WAIT:** `rst` during WAIT with one entry queued → all outputs 0 next cycle, no later `bb_rvalid`, a late `m_rvalid` is ignored, `busy`=0.
